rr_flag_gen_burst: RTL

- Parametrised successor to the round-robin flag generator used by the instruction-cache interconnect arbitration trees.
- Supplies the registered priority pointer RR_FLAG_o to one arbitration tree.
- Adds four things the old generator lacks: arbitrary master count N_MASTERS (wrap at N_MASTERS-1, not 2^WIDTH), a winner-relative "jump" mode, burst locking (pointer frozen for up to MAX_BURST handshakes), and illegal-winner detection.
- Pointer updates only on req&gnt, so the block stays clock-gating friendly.

---
 rtl/rr_flag_pkg.sv | 15 +
 rtl/rr_flag_gen_burst.sv | 108 ++++++++++
 2 files changed

// File: rtl/rr_flag_pkg.sv
// Shared types and the wrap-aware increment for the round-robin flag generator.
package rr_flag_pkg;

  typedef enum logic [0:0] {RR_INCR = 1'b0, RR_JUMP = 1'b1} rr_mode_e;
  typedef enum logic [0:0] {RR_IDLE = 1'b0, RR_HOLD = 1'b1} rr_state_e;

  // Wide enough for any legal pointer (N_MASTERS up to 256) and for n itself.
  localparam int unsigned RR_ARG_W = 9;

  function automatic logic [RR_ARG_W-1:0] wrap_inc(input logic [RR_ARG_W-1:0] x,
                                                   input logic [RR_ARG_W-1:0] n);
    return (x == n - 1'b1) ? '0 : x + 1'b1;
  endfunction

endpackage

// File: rtl/rr_flag_gen_burst.sv
// Round-robin priority pointer with INCR/JUMP advance, burst locking and
// illegal-winner flagging. Pointer moves only on a req&gnt handshake.
module rr_flag_gen_burst
  import rr_flag_pkg::*;
#(
  parameter int N_MASTERS = 5,
  parameter int WIDTH     = $clog2(N_MASTERS),
  parameter int MODE      = 0,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_req_i,
  input  logic             data_gnt_i,
  input  logic [WIDTH-1:0] winner_id_i,
  input  logic             burst_i,
  output logic [WIDTH-1:0] RR_FLAG_o,
  output logic             hold_o,
  output logic [CNT_W-1:0] burst_cnt_o,
  output logic             err_o
);

  localparam logic [0:0] S_IDLE = RR_IDLE;
  localparam logic [0:0] S_HOLD = RR_HOLD;
  localparam logic [RR_ARG_W-1:0] N_ARG = RR_ARG_W'(N_MASTERS);
  localparam bit JUMP = (MODE == int'(RR_JUMP));

  logic [WIDTH-1:0]    rr_flag_q, rr_flag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [0:0]          state_q, state_d;
  logic                err_q, err_d;

  logic                hs;
  logic                legal;
  logic [RR_ARG_W-1:0] winner_ext;
  logic [RR_ARG_W-1:0] base;
  logic [WIDTH-1:0]    next_ptr;

  assign hs         = data_req_i & data_gnt_i;
  assign winner_ext = RR_ARG_W'(winner_id_i);
  // In INCR mode the winner index is never looked at, so it cannot be illegal.
  assign legal      = JUMP ? (winner_ext < N_ARG) : 1'b1;
  assign base       = JUMP ? winner_ext : RR_ARG_W'(rr_flag_q);
  assign next_ptr   = WIDTH'(wrap_inc(base, N_ARG));

  always_comb begin
    rr_flag_d = rr_flag_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    err_d     = 1'b0;
    if (hs) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (burst_i && (MAX_BURST > 1)) begin
              state_d = S_HOLD;
              cnt_d   = CNT_W'(1);
            end else begin
              rr_flag_d = next_ptr;
            end
          end
          default: begin
            // Stay locked while beats remain; the MAX_BURST-th beat releases.
            if (burst_i && ((int'(cnt_q) + 1) < MAX_BURST)) begin
              cnt_d = cnt_q + 1'b1;
            end else begin
              rr_flag_d = next_ptr;
              cnt_d     = '0;
              state_d   = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_flag_q <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      err_q     <= 1'b0;
    end else begin
      rr_flag_q <= rr_flag_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      err_q     <= err_d;
    end
  end

  assign RR_FLAG_o   = rr_flag_q;
  assign hold_o      = (state_q == S_HOLD);
  assign burst_cnt_o = cnt_q;
  assign err_o       = err_q;

  a_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
    (RR_ARG_W'(rr_flag_q) < N_ARG));

  a_no_move_without_hs : assert property (@(posedge clk) disable iff (!rst_n)
    (rst_n && !hs) |=> (rr_flag_q == $past(rr_flag_q)));

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_HOLD) |-> (rr_flag_q == $past(rr_flag_q)));

endmodule
